// File: rtl/shiftreg_wrap.sv
// Fixed-latency pipeline: Depth register stages of {valid, data}, shifting unconditionally
// every cycle, with no backpressure. Outputs come straight from the last stage's flops.
module shiftreg_wrap #(
   parameter int unsigned Depth     = 4,
   parameter int unsigned DataWidth = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 valid_i,
   input  logic [DataWidth-1:0] data_i,
   output logic                 valid_o,
   output logic [DataWidth-1:0] data_o
);

   if (Depth < 1) begin : g_bad_depth
      $error("shiftreg_wrap: Depth must be at least 1");
   end
   if (DataWidth < 1) begin : g_bad_width
      $error("shiftreg_wrap: DataWidth must be at least 1");
   end

   // Each stage owns its flops; stage g takes its input from stage g-1, and stage 0 from the ports.
   for (genvar g = 0; g < Depth; g++) begin : g_stage
      logic                 w_valid_in;
      logic [DataWidth-1:0] w_data_in;
      logic                 r_valid;
      logic [DataWidth-1:0] r_data;

      if (g == 0) begin : g_head
         assign w_valid_in = valid_i;
         assign w_data_in  = data_i;
      end else begin : g_body
         assign w_valid_in = g_stage[g-1].r_valid;
         assign w_data_in  = g_stage[g-1].r_data;
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            r_valid <= 1'b0;
            r_data  <= '0;
         end else begin
            r_valid <= w_valid_in;
            r_data  <= w_data_in;
         end
      end
   end

   assign valid_o = g_stage[Depth-1].r_valid;
   assign data_o  = g_stage[Depth-1].r_data;

endmodule

// File: tb/tb_shiftreg_wrap.sv
// Directed bench for shiftreg_wrap: a Depth=4 instance and a Depth=1 instance, with one reset shared by both.
module tb_shiftreg_wrap;

   logic        clk;
   logic        rst_n;
   logic        v4, vo4, v1, vo1;
   logic [31:0] d4, do4, d1, do1;

   int unsigned n_checks = 0;
   int unsigned n_err    = 0;

   shiftreg_wrap #(.Depth(4), .DataWidth(32)) u_dut4 (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(v4), .data_i(d4), .valid_o(vo4), .data_o(do4)
   );

   shiftreg_wrap #(.Depth(1), .DataWidth(32)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(v1), .data_i(d1), .valid_o(vo1), .data_o(do1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Four beats go in on consecutive edges. Beat 0 is sampled at the first edge and is on the
   // outputs after the fourth edge. The data of an invalid beat is left unchecked.
   task automatic send4(input string tag, input logic [3:0] pv, input logic [3:0][31:0] pd);
      for (int i = 0; i < 4; i++) begin
         v4 = pv[i];
         d4 = pd[i];
         tick();
         if (i < 3) check({tag, "_lat_v"}, {31'd0, vo4}, 32'd0);
      end
      v4 = 1'b0;
      d4 = '0;
      for (int j = 0; j < 4; j++) begin
         check({tag, "_v"}, {31'd0, vo4}, {31'd0, pv[j]});
         if (pv[j]) check({tag, "_d"}, do4, pd[j]);
         tick();
      end
      check({tag, "_tail_v"}, {31'd0, vo4}, 32'd0);
   endtask

   logic [3:0][31:0] w;

   initial begin
      rst_n = 1'b0;
      v4 = 1'b0; d4 = '0; v1 = 1'b0; d1 = '0;
      #1;
      check("rst_t0_v", {31'd0, vo4}, 32'd0);
      check("rst_t0_d", do4, 32'd0);

      // Hold reset for 20 cycles, then release between edges and stay idle for 10 cycles
      for (int i = 0; i < 20; i++) begin
         tick();
         check("rst_hold_v", {31'd0, vo4}, 32'd0);
         check("rst_hold_d", do4, 32'd0);
      end
      #3 rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_v", {31'd0, vo4}, 32'd0);
         check("idle_d", do4, 32'd0);
         check("idle_v1", {31'd0, vo1}, 32'd0);
      end

      // Four random words on consecutive edges
      for (int i = 0; i < 4; i++) w[i] = $urandom;
      send4("rand4", 4'b1111, w);

      // A bubble in the second slot; element 0 is the first beat
      send4("bubble", 4'b1101, {32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'hA5A5_A5A5});

      // Two beats in flight, then reset is asserted between edges: neither beat may ever appear
      v4 = 1'b1; d4 = 32'h1111_1111; tick();
      v4 = 1'b1; d4 = 32'h2222_2222; tick();
      v4 = 1'b0; d4 = '0;
      #2 rst_n = 1'b0;
      #1;
      check("midrst_v", {31'd0, vo4}, 32'd0);
      check("midrst_d", do4, 32'd0);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("midrst_hold_v", {31'd0, vo4}, 32'd0);
      end
      #3 rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("midrst_after_v", {31'd0, vo4}, 32'd0);
         check("midrst_after_d", do4, 32'd0);
      end

      // Continuous stream 0..99: the beat sampled at loop step k is on the outputs after step k+3
      for (int k = 0; k < 104; k++) begin
         if (k < 100) begin
            v4 = 1'b1;
            d4 = k;
         end else begin
            v4 = 1'b0;
            d4 = '0;
         end
         tick();
         if (k >= 3 && k < 103) begin
            check("stream_v", {31'd0, vo4}, 32'd1);
            check("stream_d", do4, k - 3);
         end else begin
            check("stream_gap_v", {31'd0, vo4}, 32'd0);
         end
      end

      // Reset while the outputs hold a valid beat: they must drop without waiting for an edge
      for (int i = 0; i < 4; i++) begin
         v4 = 1'b1;
         d4 = 32'h100 + i;
         tick();
      end
      v4 = 1'b0; d4 = '0;
      check("live_pre_v", {31'd0, vo4}, 32'd1);
      check("live_pre_d", do4, 32'h100);
      #3 rst_n = 1'b0;
      #1;
      check("live_rst_v", {31'd0, vo4}, 32'd0);
      check("live_rst_d", do4, 32'd0);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("live_after_v", {31'd0, vo4}, 32'd0);
      end

      // Depth=1 instance: one-cycle latency, and data still shifts while valid is low
      check("d1_pre_v", {31'd0, vo1}, 32'd0);
      v1 = 1'b1; d1 = 32'h1234_5678;
      tick();
      check("d1_v", {31'd0, vo1}, 32'd1);
      check("d1_d", do1, 32'h1234_5678);
      v1 = 1'b0; d1 = 32'hDEAD_BEEF;
      tick();
      check("d1_after_v", {31'd0, vo1}, 32'd0);
      check("d1_after_d", do1, 32'hDEAD_BEEF);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/shiftreg_wrap.md
SHIFTREG_WRAP -- requirements
Module: shiftreg_wrap

Interface
REQ-001 Parameter Depth, default 4: number of register stages (latency in clock cycles); SHALL be >= 1, elaboration error otherwise.
REQ-002 Parameter DataWidth, default 32: payload width in bits; SHALL be >= 1.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 valid_i  input  1  input beat qualifier; sampled every rising edge.
REQ-006 data_i  input  DataWidth  input payload; sampled every rising edge.
REQ-007 valid_o  output  1  output beat qualifier; driven directly from last stage valid flop.
REQ-008 data_o  output  DataWidth  output payload; driven directly from last stage data flop.
REQ-009 The block SHALL have one clock and an asynchronous active-low reset; no other ports, no backpressure (no ready).

Function
REQ-010 Block SHALL implement Depth stages, each holding one valid bit and one DataWidth data word; stage 0 fed from inputs, stage Depth-1 drives outputs.
REQ-011 On every rising edge (rst_ni high), stage 0 SHALL load {valid_i, data_i} and stage k SHALL load stage k-1, for k = 1..Depth-1; shifting is unconditional.
REQ-012 A beat with valid_i=1 sampled at edge N SHALL appear on valid_o=1 / data_o after edge N+Depth-1, i.e. visible during the cycle following edge N+Depth-1 (Depth flop stages, Depth-cycle latency).
REQ-013 Order SHALL be preserved: beats entering on consecutive edges SHALL exit on consecutive cycles, same sequence, no reordering, duplication or loss.
REQ-014 Bubbles (valid_i=0) SHALL propagate as valid_o=0 cycles at the same relative position.
REQ-015 Data stages SHALL shift regardless of valid_i; data_o while valid_o=0 carries whatever data_i was sampled Depth edges earlier and has no meaning to consumers.
REQ-016 Outputs SHALL be purely registered; no combinational path from any input to any output.
REQ-017 Depth=1 SHALL degenerate to a single register stage, latency 1 cycle.
REQ-018 Throughput SHALL be one beat per cycle sustained indefinitely; no internal full/empty state exists.

Reset
REQ-019 While rst_ni=0, all valid bits and all data words in every stage SHALL be 0 asynchronously; valid_o=0, data_o=0 immediately on reset assertion, independent of clk_i.
REQ-020 Reset asserted mid-stream SHALL discard all in-flight beats; no beat loaded before reset SHALL ever appear on valid_o.
REQ-021 After rst_ni deasserts, first rising edge SHALL resume normal shifting from the all-zero state; valid_o SHALL stay 0 for at least Depth cycles unless valid_i is driven 1.
REQ-022 Repeated reset assertion/deassertion SHALL return the block to the identical post-reset state each time.

Verification
REQ-023 Reset hold 20 cycles, release 10 cycles idle (valid_i=0) -> valid_o=0 and data_o=0 throughout.
REQ-024 Depth=4, DataWidth=32: drive valid_i=1 with four random words W0..W3 on four consecutive edges -> valid_o rises 4 cycles after W0 sampled; data_o = W0,W1,W2,W3 on four consecutive cycles, then valid_o=0.
REQ-025 Pattern valid_i 1,0,1,1 with data 0xA5A5A5A5, 0xFFFFFFFF, 0x00000001, 0x80000000 -> valid_o 1,0,1,1 after 4-cycle latency; valid beats carry 0xA5A5A5A5, 0x00000001, 0x80000000.
REQ-026 Load two valid beats, assert rst_ni=0 asynchronously between edges for 10 cycles, release -> valid_o and data_o drop to 0 at once; neither beat ever emitted.
REQ-027 Continuous valid_i=1 with incrementing data 0..99 -> valid_o continuously 1 after latency; data_o increments by 1 every cycle with no gaps.
REQ-028 Depth=1 instance: single valid beat 0x12345678 -> valid_o=1, data_o=0x12345678 exactly one cycle later, for one cycle.
